piso_serializer: RTL and testbench

- Parallel-in, serial-out transmitter: accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on ser_out.
- Qualifiers ser_valid and frame_last accompany the serial stream.
- Contains a one-entry holding buffer, so consecutive words stream with no idle gap between frames.
- Sits at the transmit end of the team's bit-serial links and feeds the serial-in shift register receiver.

---
 rtl/serial_pkg.sv | 22 ++
 rtl/piso_serializer_hold_buffer.sv | 41 ++++
 rtl/piso_serializer.sv | 133 +++++++++++++
 tb/tb_piso_serializer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial link: state encoding, default frame width and
// a reference bit-order helper.
package serial_pkg;

  localparam int unsigned SER_WIDTH = 4;
  localparam int unsigned SER_CNT_W = $clog2(SER_WIDTH);

  typedef logic [0:0] ser_state_t;
  localparam ser_state_t IDLE  = 1'b0;
  localparam ser_state_t SHIFT = 1'b1;

  typedef logic [SER_CNT_W-1:0] ser_idx_t;

  // Bit sent in position idx of a SER_WIDTH-bit frame.
  function automatic logic ser_bit(input logic [SER_WIDTH-1:0] word, input ser_idx_t idx,
                                   input bit msb_first);
    ser_idx_t pos;
    pos = msb_first ? (ser_idx_t'(SER_WIDTH - 1) - idx) : idx;
    return word[pos];
  endfunction

endpackage

// File: rtl/piso_serializer_hold_buffer.sv
// One-entry register slice holding the next word while the current frame shifts out.
module ser_hold_buffer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             hold_full,
  output logic [WIDTH-1:0] hold_data
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (wr_en) begin
      full_d = 1'b1;
      data_d = wr_data;
    end else if (rd_en) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign hold_full = full_q;
  assign hold_data = data_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with a one-entry holding buffer for gapless frames.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH      = SER_WIDTH,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_last,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  ser_state_t      state_q, state_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic            ser_out_q, ser_out_d;
  logic            ser_valid_q, ser_valid_d;

  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             hold_wr, hold_rd;
  logic             accept, end_of_frame, load;
  logic [WIDTH-1:0] load_data;

  assign in_ready     = !hold_full && !reset;
  assign accept       = in_valid && in_ready;
  assign end_of_frame = (state_q == SHIFT) && (bit_cnt_q == LastCnt);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ser_out_d   = ser_out_q;
    ser_valid_d = ser_valid_q;
    hold_wr     = 1'b0;
    hold_rd     = 1'b0;
    load        = 1'b0;
    load_data   = in_data;

    case (state_q)
      IDLE: begin
        if (accept) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (end_of_frame) begin
          if (hold_full) begin
            load      = 1'b1;
            load_data = hold_data;
            hold_rd   = 1'b1;
          end else if (accept) begin
            load = 1'b1;
          end else begin
            state_d     = IDLE;
            bit_cnt_d   = '0;
            ser_valid_d = 1'b0;
            ser_out_d   = IDLE_LEVEL;
          end
        end else begin
          hold_wr   = accept;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (MSB_FIRST) begin
            ser_out_d = shift_q[WIDTH-1];
            shift_d   = {shift_q[WIDTH-2:0], 1'b0};
          end else begin
            ser_out_d = shift_q[0];
            shift_d   = {1'b0, shift_q[WIDTH-1:1]};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The first bit goes straight to the output flop; the rest wait in the shift register.
    if (load) begin
      bit_cnt_d   = '0;
      ser_valid_d = 1'b1;
      if (MSB_FIRST) begin
        ser_out_d = load_data[WIDTH-1];
        shift_d   = {load_data[WIDTH-2:0], 1'b0};
      end else begin
        ser_out_d = load_data[0];
        shift_d   = {1'b0, load_data[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ser_out_q   <= IDLE_LEVEL;
      ser_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
    end
  end

  ser_hold_buffer #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (hold_wr),
    .wr_data  (in_data),
    .rd_en    (hold_rd),
    .hold_full(hold_full),
    .hold_data(hold_data)
  );

  assign ser_out    = ser_out_q;
  assign ser_valid  = ser_valid_q;
  assign frame_last = ser_valid_q && (bit_cnt_q == LastCnt) && !reset;
  assign busy       = ((state_q == SHIFT) || hold_full) && !reset;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB- and LSB-first instances, streaming, bypass, reset.
module tb_piso_serializer;
  import serial_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_valid_l;
  logic [3:0] in_data, in_data_l;
  logic       in_ready, in_ready_l;
  logic       ser_out, ser_valid, frame_last, busy;
  logic       ser_out_l, ser_valid_l, frame_last_l, busy_l;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .frame_last(frame_last),
    .busy      (busy)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid_l),
    .in_ready  (in_ready_l),
    .in_data   (in_data_l),
    .ser_out   (ser_out_l),
    .ser_valid (ser_valid_l),
    .frame_last(frame_last_l),
    .busy      (busy_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic b, input logic last);
    check({tag, "_valid"}, ser_valid, 1'b1);
    check({tag, "_out"}, ser_out, b);
    check({tag, "_last"}, frame_last, last);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, ser_valid, 1'b0);
    check({tag, "_out"}, ser_out, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  logic [3:0] exp_a[4];
  logic [3:0] exp_l[4];
  logic [7:0] exp_b;
  logic [3:0] words[3];
  logic       acc, started, gap;
  int         widx, nb;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_valid_l = 1'b0; in_data_l = '0;
    tick();
    tick();
    // Reset state
    check("rst_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_last", frame_last, 1'b0);
    check("rst_valid", ser_valid, 1'b0);
    reset = 1'b0;
    tick();
    check("idle_ready", in_ready, 1'b1);
    check_idle("idle");

    // Single frame 1011 on both bit orders
    in_valid = 1'b1; in_data = 4'b1011; in_valid_l = 1'b1; in_data_l = 4'b1011;
    tick();
    in_valid = 1'b0; in_valid_l = 1'b0;
    exp_a[0] = 4'd1; exp_a[1] = 4'd0; exp_a[2] = 4'd1; exp_a[3] = 4'd1;
    exp_l[0] = 4'd1; exp_l[1] = 4'd1; exp_l[2] = 4'd0; exp_l[3] = 4'd1;
    for (int i = 0; i < 4; i++) begin
      check_bit("msb", exp_a[i][0], i == 3);
      check("lsb_valid", ser_valid_l, 1'b1);
      check("lsb_out", ser_out_l, exp_l[i][0]);
      check("lsb_last", frame_last_l, i == 3);
      tick();
    end
    check_idle("msb_end");
    check("lsb_end_valid", ser_valid_l, 1'b0);
    tick();

    // Back-to-back 1011 then 0110 via the holding buffer
    exp_b = 8'b1011_0110;
    in_valid = 1'b1; in_data = 4'b1011;
    tick();
    for (int i = 0; i < 8; i++) begin
      check_bit("b2b", exp_b[7-i], (i == 3) || (i == 7));
      check("b2b_ready", in_ready, (i == 0) || (i >= 4));
      if (i == 0) in_data = 4'b0110;
      if (i == 1) in_valid = 1'b0;
      tick();
    end
    check_idle("b2b_end");
    tick();

    // Backpressure: three words with in_valid held high
    words[0] = 4'b1011; words[1] = 4'b0110; words[2] = 4'b1100;
    widx = 0; nb = 0; started = 1'b0; gap = 1'b0;
    in_valid = 1'b1; in_data = words[0];
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (ser_valid) begin
        started = 1'b1;
        if (nb < 12) begin
          check("bp_bit", ser_out, ser_bit(words[nb/4], ser_idx_t'(nb % 4), 1'b1));
          check("bp_last", frame_last, (nb % 4) == 3);
        end
        nb++;
      end else if (started && nb < 12) begin
        gap = 1'b1;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        widx++;
        if (widx < 3) in_data = words[widx];
        else in_valid = 1'b0;
      end
    end
    check("bp_words", widx, 3);
    check("bp_count", nb, 12);
    check("bp_gap", gap, 1'b0);
    check_idle("bp_end");

    // Bypass: next word presented exactly on the frame-last cycle
    in_valid = 1'b1; in_data = 4'b1011;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_bit("byp1", exp_a[i][0], i == 3);
      if (i == 3) begin
        check("byp_ready_last", in_ready, 1'b1);
        in_valid = 1'b1; in_data = 4'b1100;
      end
      tick();
    end
    in_valid = 1'b0;
    exp_a[0] = 4'd1; exp_a[1] = 4'd1; exp_a[2] = 4'd0; exp_a[3] = 4'd0;
    for (int i = 0; i < 4; i++) begin
      check_bit("byp2", exp_a[i][0], i == 3);
      check("byp_hold_empty", in_ready, 1'b1);
      tick();
    end
    check_idle("byp_end");

    // Reset mid-frame with a word held
    in_valid = 1'b1; in_data = 4'b1011;
    tick();
    in_data = 4'b0110;
    check_bit("rmf_b0", 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    check_bit("rmf_b1", 1'b0, 1'b0);
    check("rmf_held", in_ready, 1'b0);
    reset = 1'b1;
    tick();
    check_idle("rmf_rst");
    check("rmf_rst_ready", in_ready, 1'b0);
    reset = 1'b0;
    tick();
    check("rmf_ready", in_ready, 1'b1);
    check_idle("rmf_after");
    tick();
    check_idle("rmf_after2");
    in_valid = 1'b1; in_data = 4'b0001;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_bit("rmf_new", i == 3, i == 3);
      tick();
    end
    check_idle("rmf_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
